icg_enable_ctrl: RTL and testbench
==================================

ICG_ENABLE_CTRL -- requirements
Module: icg_enable_ctrl

Interface
REQ-001: The block SHALL have parameter IDLE_CYC, default 8, meaning consecutive idle cycles before a channel's clock is gated (legal range 1..255).
REQ-002: The block SHALL have parameter WAKE_LAT, default 2, meaning cycles from enable assertion to ready (legal range 1..15).
REQ-003: The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-004: The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005: The block SHALL have port force_on, input, 1 bit, which forces all channels to wake and blocks idle timeout.
REQ-006: The block SHALL have port req, input, 2 bits, per-channel activity request.
REQ-007: The block SHALL have port en, output, 2 bits, per-channel registered clock-gate enable driving the ICG cells.
REQ-008: The block SHALL have port ready, output, 2 bits, per-channel registered flag meaning the gated clock is stable and usable.
REQ-009: The block SHALL have port wake_cnt, output, 8 bits, total count of granted wake events, saturating.

Function
REQ-010: Each channel SHALL run an independent FSM with states GATED (en=0, ready=0), WAKE (en=1, ready=0) and ACTIVE (en=1, ready=1).
REQ-011: A channel in GATED with req or force_on high SHALL become a wake candidate.
REQ-012: At most one channel SHALL be granted GATED->WAKE per clock edge to limit inrush.
REQ-013: With both channels as candidates, the grant SHALL follow a round-robin pointer that favours channel 0 after reset and moves to the non-granted channel after every grant.
REQ-014: With a single candidate, that channel SHALL be granted regardless of the pointer, and the pointer SHALL still move to the other channel.
REQ-015: A candidate sampled at edge N SHALL have en=1 after edge N, and ready=1 exactly WAKE_LAT edges later.
REQ-016: A channel in WAKE SHALL complete its wake sequence even if req drops, then enter ACTIVE.
REQ-017: In ACTIVE, an idle counter SHALL increment on each edge where req=0 and force_on=0, and SHALL clear to 0 on any edge where req=1 or force_on=1.
REQ-018: When the idle counter reaches IDLE_CYC, the channel SHALL move to GATED on the same edge, clearing en and ready together.
REQ-019: Idle counting SHALL be suppressed while the channel is in WAKE.
REQ-020: If req rises on the same edge on which the idle count reaches IDLE_CYC, the req SHALL win and the channel SHALL stay ACTIVE with the counter cleared.
REQ-021: A channel reaching GATED SHALL be eligible for re-grant no earlier than the following edge.
REQ-022: wake_cnt SHALL increment by 1 per grant and SHALL hold at 255.

Reset
REQ-023: While rst_n=0, the block SHALL asynchronously force all channels to GATED, en=2'b00, ready=2'b00, all counters to 0, wake_cnt=0 and the RR pointer to channel 0.
REQ-024: Reset asserted mid-WAKE or mid-ACTIVE SHALL abort the sequence without glitching en high.
REQ-025: The first grant SHALL be possible on the first edge after rst_n deasserts.

Structure
REQ-026: Package icg_ctrl_pkg SHALL hold the channel state enum (GATED/WAKE/ACTIVE), the channel count (2) and the default IDLE_CYC/WAKE_LAT values.
REQ-027: Sub-module icg_chan_fsm SHALL implement one channel (FSM, wake timer, idle counter) and SHALL be instantiated twice, with the arbiter and wake_cnt in the top.

Verification
REQ-028: Wake scenario: reset, then req=2'b01 at edge 1 -> en[0]=1 after edge 1, ready[0]=1 after edge 3, wake_cnt=1.
REQ-029: Simultaneous-request scenario: req=2'b11 from reset -> channel 0 enters WAKE at edge 1 and channel 1 at edge 2; ready[0] after edge 3 and ready[1] after edge 4.
REQ-030: Idle-timeout scenario: channel 0 ACTIVE, then req[0]=0 -> en[0] and ready[0] drop after exactly 8 idle edges; a req[0] pulse at idle count 5 restarts the count.
REQ-031: force_on scenario: force_on=1 with req=0 -> both channels wake in RR order and stay ACTIVE for 100 cycles; after force_on drops, both gate 8 edges later.
REQ-032: Reset scenario: assert rst_n=0 mid-WAKE on channel 1 -> en and ready go to 0 immediately; after release, req[1] sees a fresh wake with full WAKE_LAT latency.
REQ-033: Saturation scenario: 300 wake/gate cycles -> wake_cnt holds at 255 with no wrap.

Source files
------------

// File: rtl/icg_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
// Channel state encoding plus channel count and timing defaults.
package icg_ctrl_pkg;

  typedef enum logic [1:0] {
    GATED  = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } chan_state_t;

  localparam int N_CHAN       = 2;
  localparam int DEF_IDLE_CYC = 8;
  localparam int DEF_WAKE_LAT = 2;

endpackage

// File: rtl/icg_chan_fsm.sv
// One gated-clock channel: GATED/WAKE/ACTIVE FSM,
// wake-latency timer and idle-timeout counter.
import icg_ctrl_pkg::*;

module icg_chan_fsm #(
  parameter int IDLE_CYC = DEF_IDLE_CYC,
  parameter int WAKE_LAT = DEF_WAKE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic force_on,
  input  logic grant,
  output logic cand,
  output logic en,
  output logic ready
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_LAT - 1);

  chan_state_t state_q;
  logic [7:0]  idle_q;
  logic [3:0]  wtmr_q;
  logic        busy;

  assign busy = req | force_on;
  assign cand = (state_q == GATED) && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GATED;
      en      <= 1'b0;
      ready   <= 1'b0;
      idle_q  <= '0;
      wtmr_q  <= '0;
    end else begin
      unique case (state_q)
        GATED: begin
          if (grant) begin
            state_q <= WAKE;
            en      <= 1'b1;
            wtmr_q  <= '0;
          end
        end
        WAKE: begin
          if (wtmr_q == WAKE_LAST) begin
            state_q <= ACTIVE;
            ready   <= 1'b1;
            idle_q  <= '0;
          end else begin
            wtmr_q <= wtmr_q + 4'd1;
          end
        end
        ACTIVE: begin
          // activity on the timeout edge keeps the clock running
          if (busy) begin
            idle_q <= '0;
          end else if (idle_q == IDLE_LAST) begin
            state_q <= GATED;
            en      <= 1'b0;
            ready   <= 1'b0;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 8'd1;
          end
        end
        default: begin
          state_q <= GATED;
          en      <= 1'b0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/icg_enable_ctrl.sv
// Two-channel ICG enable controller: one wake grant per edge,
// round-robin between channels, saturating wake counter.
import icg_ctrl_pkg::*;

module icg_enable_ctrl #(
  parameter int IDLE_CYC = DEF_IDLE_CYC,
  parameter int WAKE_LAT = DEF_WAKE_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              force_on,
  input  logic [N_CHAN-1:0] req,
  output logic [N_CHAN-1:0] en,
  output logic [N_CHAN-1:0] ready,
  output logic [7:0]        wake_cnt
);

  logic [N_CHAN-1:0] cand;
  logic [N_CHAN-1:0] grant;
  logic              ptr_q;

  // ptr_q=1 favours channel 1 when both want to wake
  always_comb begin
    grant = '0;
    case (cand)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= 1'b0;
      wake_cnt <= '0;
    end else if (|grant) begin
      ptr_q <= grant[0];
      if (wake_cnt != 8'hFF) begin
        wake_cnt <= wake_cnt + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    icg_chan_fsm #(
      .IDLE_CYC(IDLE_CYC),
      .WAKE_LAT(WAKE_LAT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req[i]),
      .force_on (force_on),
      .grant    (grant[i]),
      .cand     (cand[i]),
      .en       (en[i]),
      .ready    (ready[i])
    );
  end

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Bench for icg_enable_ctrl: per-edge vector tables fed through
// a scoreboard queue, plus reset and saturation sequences.
module tb_icg_enable_ctrl;

  typedef struct {
    logic [1:0] req;
    logic       frc;
    logic [1:0] en;
    logic [1:0] rdy;
    logic [7:0] wc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_on = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] en;
  logic [1:0] ready;
  logic [7:0] wake_cnt;

  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  vec_t vecs[$];
  vec_t sb[$];

  icg_enable_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .force_on (force_on),
    .req      (req),
    .en       (en),
    .ready    (ready),
    .wake_cnt (wake_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(string nm, int id, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, id, act, exp);
    end
  endtask

  function automatic void add(int n, logic [1:0] r, logic f,
                              logic [1:0] e, logic [1:0] rd,
                              logic [7:0] w);
    vec_t v;
    v.req = r;
    v.frc = f;
    v.en  = e;
    v.rdy = rd;
    v.wc  = w;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check_out();
    vec_t e;
    vec_id++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: empty, expected entry",
               vec_id);
    end else begin
      e = sb.pop_front();
      cmp("en", vec_id, int'(en), int'(e.en));
      cmp("ready", vec_id, int'(ready), int'(e.rdy));
      cmp("wake_cnt", vec_id, int'(wake_cnt), int'(e.wc));
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic apply(vec_t v);
    req = v.req;
    force_on = v.frc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 2'b00;
    force_on = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_en", vec_id, int'(en), 0);
    cmp("rst_ready", vec_id, int'(ready), 0);
    cmp("rst_wake_cnt", vec_id, int'(wake_cnt), 0);
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    do_reset();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    vec_t v;

    // single wake, idle timeout, RR from ptr=1, idle restart
    add(1, 2'b01, 0, 2'b01, 2'b00, 8'd1);
    add(1, 2'b00, 0, 2'b01, 2'b00, 8'd1);
    add(1, 2'b00, 0, 2'b01, 2'b01, 8'd1);
    add(7, 2'b00, 0, 2'b01, 2'b01, 8'd1);
    add(2, 2'b00, 0, 2'b00, 2'b00, 8'd1);
    add(1, 2'b11, 0, 2'b10, 2'b00, 8'd2);
    add(1, 2'b11, 0, 2'b11, 2'b00, 8'd3);
    add(1, 2'b01, 0, 2'b11, 2'b10, 8'd3);
    add(7, 2'b01, 0, 2'b11, 2'b11, 8'd3);
    add(1, 2'b01, 0, 2'b01, 2'b01, 8'd3);
    add(5, 2'b00, 0, 2'b01, 2'b01, 8'd3);
    add(1, 2'b01, 0, 2'b01, 2'b01, 8'd3);
    add(7, 2'b00, 0, 2'b01, 2'b01, 8'd3);
    add(2, 2'b00, 0, 2'b00, 2'b00, 8'd3);
    run_table();

    // simultaneous request, req on timeout edge, single-cand grant
    add(1, 2'b11, 0, 2'b01, 2'b00, 8'd1);
    add(1, 2'b11, 0, 2'b11, 2'b00, 8'd2);
    add(1, 2'b11, 0, 2'b11, 2'b01, 8'd2);
    add(1, 2'b11, 0, 2'b11, 2'b11, 8'd2);
    add(7, 2'b00, 0, 2'b11, 2'b11, 8'd2);
    add(1, 2'b11, 0, 2'b11, 2'b11, 8'd2);
    add(7, 2'b00, 0, 2'b11, 2'b11, 8'd2);
    add(2, 2'b00, 0, 2'b00, 2'b00, 8'd2);
    add(1, 2'b10, 0, 2'b10, 2'b00, 8'd3);
    run_table();

    // force_on holds both channels awake
    add(1, 2'b00, 1, 2'b01, 2'b00, 8'd1);
    add(1, 2'b00, 1, 2'b11, 2'b00, 8'd2);
    add(1, 2'b00, 1, 2'b11, 2'b01, 8'd2);
    add(101, 2'b00, 1, 2'b11, 2'b11, 8'd2);
    add(7, 2'b00, 0, 2'b11, 2'b11, 8'd2);
    add(2, 2'b00, 0, 2'b00, 2'b00, 8'd2);
    run_table();

    // reset mid-wake on channel 1, then a fresh full-latency wake
    do_reset();
    add(2, 2'b10, 0, 2'b10, 2'b00, 8'd1);
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_en", vec_id, int'(en), 0);
    cmp("async_rst_ready", vec_id, int'(ready), 0);
    cmp("async_rst_wake_cnt", vec_id, int'(wake_cnt), 0);
    @(posedge clk);
    #1;
    cmp("held_rst_en", vec_id, int'(en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    add(2, 2'b10, 0, 2'b10, 2'b00, 8'd1);
    add(1, 2'b10, 0, 2'b10, 2'b10, 8'd1);
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    // 300 wake/gate rounds on channel 0
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v.req = 2'b01;
      v.frc = 1'b0;
      v.en  = 2'b01;
      v.rdy = 2'b00;
      v.wc  = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      apply(v);
      req = 2'b00;
      repeat (9) @(negedge clk);
      v.req = 2'b00;
      v.en  = 2'b00;
      apply(v);
    end

    cmp("sb_drained", vec_id, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
